sdff_s_x2: RTL and testbench
============================

SDFF_S_X2 -- requirements
Module: sdff_s_x2

Interface
REQ-001: Parameter WIDTH, default 1, number of independent scan flip-flop bits.
REQ-002: CK  input  1  clock; all synchronous capture on the rising edge.
REQ-003: RST  input  1  reset, asynchronous, active-high; declared tri0 so an unconnected RST reads inactive.
REQ-004: D  input  WIDTH  functional data.
REQ-005: SE  input  1  scan enable; 1 selects SI, 0 selects D.
REQ-006: SI  input  WIDTH  scan data.
REQ-007: SN  input  1  asynchronous set, active-low.
REQ-008: Q  output  WIDTH  stored state.
REQ-009: QN  output  WIDTH  complement of Q.
REQ-010: Positional port order SHALL be D, SE, SI, SN, CK, Q, QN, RST, so 7-port positional instances remain legal.

Function
REQ-011: On a CK rising edge with RST=0 and SN=1, each bit Q[i] SHALL load SE ? SI[i] : D[i].
REQ-012: CK falling edges and level changes of D, SI and SE SHALL NOT change Q.
REQ-013: SN=0 with RST=0 SHALL force Q to all-ones immediately, with no clock required, and hold it while asserted, ignoring CK.
REQ-014: RST=1 SHALL force Q to all-zeros immediately and dominate SN; RST=1 with SN=0 gives Q=0 and QN=1.
REQ-015: QN SHALL equal ~Q at all times, including during set, reset and after release.
REQ-016: On release of SN or RST, Q SHALL hold the forced value until the next qualifying rising edge of CK.
REQ-017: A CK edge that coincides with SN or RST asserted SHALL be ignored.
REQ-018: Latency is one CK rising edge from D or SI to Q; there is no handshake and no internal state beyond Q.
REQ-019: Bits SHALL be independent; SE, SN, RST and CK are shared by all bits.

Reset
REQ-020: RST asserted SHALL give Q=0 and QN=all-ones for every bit, asynchronously, with RST taking priority over SN.
REQ-021: Without RST or SN asserted since power-up, Q is X until the first capture; no initial value SHALL be modelled.

Structure
REQ-022: A shared package SHALL hold the default WIDTH constant and the reset and set values (all-zeros and all-ones).
REQ-023: One sub-module, sdff_s_bit, SHALL implement a single bit (mux, flop, async set/reset, QN); sdff_s_x2 SHALL instantiate WIDTH copies via generate.
REQ-024: The design SHALL contain no latches and no combinational path from D, SI or SE to Q.

Verification
REQ-025: SN=0, RST=0, CK=0, D=0, SE=0 -> Q=1, QN=0 with no clock edge.
REQ-026: SN=1, SE=0, D=0, SI=1, CK 0->1 -> Q=0, QN=1; then D=1 with CK 1->0 -> Q remains 0.
REQ-027: SN=1, SE=1, D=0, SI=1, CK 0->1 -> Q=1, QN=0; then SI=0, CK 0->1 -> Q=0.
REQ-028: Q=1, RST pulsed 1 mid-cycle with SN=0 and CK static -> Q=0, QN=1; RST released with SN=1 -> Q stays 0 until the next rising edge.
REQ-029: SN=0 held while CK toggles with D=0, SE=0 -> Q stays 1; SN released -> first rising edge loads D=0.
REQ-030: WIDTH=4, SE=0, D=4'b1010, SN=1, CK 0->1 -> Q=4'b1010, QN=4'b0101.

Source files
------------

// File: rtl/sdff_s_x2_pkg.sv
// Shared constants for the sdff_s_x2 scan flip-flop array.
// Holds the default width, the reset and set values, and the scan-mux select helper.
package sdff_s_x2_pkg;

   localparam int   DEFAULT_WIDTH = 1;
   localparam logic RST_VAL       = 1'b0;
   localparam logic SET_VAL       = 1'b1;

   // Scan mux: SE high selects the scan chain input over functional data.
   function automatic logic scan_sel(input logic se, input logic si, input logic d);
      return se ? si : d;
   endfunction

endpackage

// File: rtl/sdff_s_bit.sv
// One scan flip-flop bit: scan mux into a rising-edge flop with async set (active-low)
// and async reset (active-high, dominant), plus complementary output.
module sdff_s_bit
   import sdff_s_x2_pkg::*;
(
   input  logic d,
   input  logic se,
   input  logic si,
   input  logic sn,
   input  logic ck,
   input  logic rst,
   output logic q,
   output logic qn
);

   // Reset is tested first so it wins when set and reset are both asserted.
   always_ff @(posedge ck or posedge rst or negedge sn) begin
      if (rst)
         q <= RST_VAL;
      else if (!sn)
         q <= SET_VAL;
      else
         q <= scan_sel(se, si, d);
   end

   assign qn = ~q;

endmodule

// File: rtl/sdff_s_x2.sv
// WIDTH independent scan flip-flops sharing clock, scan enable, set and reset.
// Positional port order is fixed so legacy 7-port instances leave RST floating low.
module sdff_s_x2
   import sdff_s_x2_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] D,
   input  logic             SE,
   input  logic [WIDTH-1:0] SI,
   input  logic             SN,
   input  logic             CK,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN,
   input  tri0              RST
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sdff_s_bit u_bit (
         .d  (D[i]),
         .se (SE),
         .si (SI[i]),
         .sn (SN),
         .ck (CK),
         .rst(RST),
         .q  (Q[i]),
         .qn (QN[i])
      );
   end

endmodule

// File: tb/tb_sdff_s_x2.sv
// Bench for sdff_s_x2 at WIDTH=4: directed async set/reset cases plus randomized
// capture, level-change and async-pulse traffic against a bench-side reference model.
module tb_sdff_s_x2;

   localparam int W = 4;

   logic [W-1:0] D, SI;
   logic         SE, SN, CK, RST;
   wire  [W-1:0] Q, QN;

   logic [W-1:0] exp_q;
   int           vectors = 0;
   int           errors  = 0;

   sdff_s_x2 #(.WIDTH(W)) dut (
      .D  (D),
      .SE (SE),
      .SI (SI),
      .SN (SN),
      .CK (CK),
      .Q  (Q),
      .QN (QN),
      .RST(RST)
   );

   // Rising edge: every bit captures its own selected input unless set or reset is active.
   task automatic rise();
      #4;
      if (!RST && SN)
         for (int i = 0; i < W; i++) exp_q[i] = SE ? SI[i] : D[i];
      CK = 1'b1;
      #1;
   endtask

   task automatic fall();
      #4 CK = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b0; SN = 1'b1; CK = 1'b0; D = '0; SE = 1'b0; SI = '0;
      #2 RST = 1'b1;
      #1 exp_q = '0;
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL reset_async: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      SN = 1'b0;
      #1 vectors++;
      if (Q !== 4'b0000 || QN !== 4'b1111) begin errors++; $display("FAIL reset_over_set: Q=%b QN=%b want Q=0000 QN=1111", Q, QN); end
      D = '1;
      rise();
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL reset_ignores_clk: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      fall();
      SN = 1'b1;
      #1 RST = 1'b0;
      #1 vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL reset_release_hold: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
   endtask

   task automatic test_set();
      D = '0; SE = 1'b0; CK = 1'b0;
      SN = 1'b0;
      #1 exp_q = '1;
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL set_async: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      repeat (3) begin
         D = W'($urandom); SI = W'($urandom); SE = 1'($urandom);
         rise();
         vectors++;
         if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL set_ignores_clk: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
         fall();
      end
      D = '0; SE = 1'b0;
      SN = 1'b1;
      #1 vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL set_release_hold: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      rise();
      vectors++;
      if (Q !== 4'b0000 || QN !== 4'b1111) begin errors++; $display("FAIL set_release_first_edge: Q=%b QN=%b want Q=0000", Q, QN); end
      fall();
   endtask

   task automatic test_capture();
      SE = 1'b0; D = '0; SI = '1;
      rise();
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL cap_d0: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      D = '1;
      fall();
      vectors++;
      if (Q !== 4'b0000) begin errors++; $display("FAIL cap_fall_hold: Q=%b want 0000", Q); end
      SE = 1'b1; D = '0; SI = '1;
      rise();
      vectors++;
      if (Q !== 4'b1111 || QN !== 4'b0000) begin errors++; $display("FAIL cap_si: Q=%b QN=%b want Q=1111", Q, QN); end
      fall();
      SI = '0;
      rise();
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL cap_si0: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      fall();
      SE = 1'b0; D = 4'b1010;
      rise();
      vectors++;
      if (Q !== 4'b1010 || QN !== 4'b0101) begin errors++; $display("FAIL cap_1010: Q=%b QN=%b want Q=1010 QN=0101", Q, QN); end
      fall();
   endtask

   task automatic test_coincident();
      D = '0; SE = 1'b0;
      SN = 1'b0;
      exp_q = '1;
      rise();
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL edge_during_set: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      fall();
      SN = 1'b1;
      D = '1;
      RST = 1'b1;
      exp_q = '0;
      rise();
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL edge_during_reset: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      fall();
      RST = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid();
      SE = 1'b0; D = '1;
      rise();
      #2 SN = 1'b0;
      RST = 1'b1;
      #1 exp_q = '0;
      vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL reset_mid_cycle: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      SN = 1'b1;
      #1 RST = 1'b0;
      #1 vectors++;
      if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL reset_mid_release: Q=%b QN=%b want Q=%b", Q, QN, exp_q); end
      fall();
      vectors++;
      if (Q !== exp_q) begin errors++; $display("FAIL reset_mid_fall: Q=%b want %b", Q, exp_q); end
      rise();
      vectors++;
      if (Q !== 4'b1111 || QN !== 4'b0000) begin errors++; $display("FAIL reset_mid_next_edge: Q=%b QN=%b want Q=1111", Q, QN); end
      fall();
   endtask

   task automatic test_random();
      int op;
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 9);
         D = W'($urandom); SI = W'($urandom); SE = 1'($urandom);
         rise();
         vectors++;
         if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_capture[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
         D = W'($urandom); SI = W'($urandom); SE = 1'($urandom);
         #1 vectors++;
         if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_level_hold[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
         if (op == 8) begin
            SN = 1'b0;
            #1 exp_q = '1;
            vectors++;
            if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_set[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
            SN = 1'b1;
            #1 vectors++;
            if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_set_release[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
         end else if (op == 9) begin
            RST = 1'b1;
            SN  = 1'($urandom);
            #1 exp_q = '0;
            vectors++;
            if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_reset[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
            SN = 1'b1;
            #1 RST = 1'b0;
            #1 vectors++;
            if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_reset_release[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
         end
         fall();
         vectors++;
         if (Q !== exp_q || QN !== ~exp_q) begin errors++; $display("FAIL rand_fall_hold[%0d]: Q=%b QN=%b want Q=%b", n, Q, QN, exp_q); end
      end
   endtask

   initial begin
      exp_q = 'x;
      test_reset();
      test_set();
      test_capture();
      test_coincident();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
